// File: rtl/fnd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fnd_pkg                                                       |
// | Purpose  : Shared constants for the FND scan controller and the          |
// |            downstream 7-segment decoder.                                 |
// | Contents : FND_NIBBLE_W   - width of one displayed hex digit             |
// |            FND_MAX_DIGITS - widest display the common-off constant covers|
// |            FND_COM_OFF    - all digit commons released (active-low)      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package fnd_pkg;

   localparam int FND_NIBBLE_W   = 4;
   localparam int FND_MAX_DIGITS = 32;

   // Commons are active-low, so "all off" is all ones; users slice the low
   // DIGITS bits for their display width.
   localparam logic [FND_MAX_DIGITS-1:0] FND_COM_OFF = '1;

endpackage : fnd_pkg
`default_nettype wire

// File: rtl/fnd_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fnd_scan                                                      |
// | Purpose  : Time-multiplexed scan controller for a common-anode           |
// |            multi-digit 7-segment display. Holds a frame-stable copy of   |
// |            a packed hex value and walks the digits one slot at a time.   |
// | Ports    : clk        in  system clock                                   |
// |            rst        in  synchronous reset, active-high                 |
// |            value      in  packed hex digits, digit 0 in bits [3:0]       |
// |            load       in  strobe capturing value / dp_in                 |
// |            dp_in      in  per-digit decimal point request, active-high   |
// |            blank_lz   in  leading-zero blanking enable (level)           |
// |            number     out nibble for the segment decoder                 |
// |            com_n      out digit commons, active-low, at most one low     |
// |            dp_n       out decimal point, active-low                      |
// |            frame_tick out one-cycle pulse after each frame wrap          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fnd_scan
   import fnd_pkg::*;
#(
   parameter int DIGITS  = 4,
   parameter int CLK_HZ  = 50_000_000,
   parameter int SCAN_HZ = 1000,
   parameter int GUARD   = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [FND_NIBBLE_W*DIGITS-1:0] value,
   input  logic                           load,
   input  logic [DIGITS-1:0]              dp_in,
   input  logic                           blank_lz,
   output logic [FND_NIBBLE_W-1:0]        number,
   output logic [DIGITS-1:0]              com_n,
   output logic                           dp_n,
   output logic                           frame_tick
);

   localparam int C_DIV   = CLK_HZ / SCAN_HZ;
   localparam int C_CNT_W = (C_DIV > 1) ? $clog2(C_DIV) : 1;
   localparam int C_IDX_W = $clog2(DIGITS);

   localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(C_DIV - 1);
   localparam logic [C_CNT_W-1:0] C_GUARD    = C_CNT_W'(GUARD);
   localparam logic [C_IDX_W-1:0] C_IDX_LAST = C_IDX_W'(DIGITS - 1);
   localparam logic [DIGITS-1:0]  C_COM_OFF  = FND_COM_OFF[DIGITS-1:0];
   localparam logic [DIGITS-1:0]  C_ONE      = DIGITS'(1);

   // Scan position
   logic [C_CNT_W-1:0] r_cnt;
   logic [C_IDX_W-1:0] r_idx;

   // Shadow registers: pend collects loads, act is what is on the glass
   logic [DIGITS-1:0][FND_NIBBLE_W-1:0] r_pend;
   logic [DIGITS-1:0]                   r_pend_dp;
   logic                                r_pend_v;
   logic [DIGITS-1:0][FND_NIBBLE_W-1:0] r_act;
   logic [DIGITS-1:0]                   r_act_dp;

   // Registered outputs
   logic [FND_NIBBLE_W-1:0] r_number;
   logic [DIGITS-1:0]       r_com_n;
   logic                    r_dp_n;
   logic                    r_frame_tick;

   logic              w_slot_end;
   logic              w_frame_end;
   logic              w_zero_run;
   logic [DIGITS-1:0] w_blank;
   logic              w_lit;

   assign w_slot_end  = (r_cnt == C_CNT_LAST);
   assign w_frame_end = w_slot_end && (r_idx == C_IDX_LAST);

   // Leading-zero mask: walk down from the most significant digit and keep
   // blanking while every nibble seen so far is zero. Digit 0 always shows.
   always_comb begin
      w_zero_run = 1'b1;
      w_blank    = '0;
      for (int i = DIGITS - 1; i > 0; i--) begin
         w_zero_run = w_zero_run & (r_act[i] == '0);
         w_blank[i] = blank_lz & w_zero_run;
      end
   end

   // The common is driven only after the guard cycles of the slot, and only
   // for digits that survive blanking.
   assign w_lit = (r_cnt >= C_GUARD) && !w_blank[r_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt        <= '0;
         r_idx        <= '0;
         r_pend       <= '0;
         r_pend_dp    <= '0;
         r_pend_v     <= 1'b0;
         r_act        <= '0;
         r_act_dp     <= '0;
         r_number     <= '0;
         r_com_n      <= C_COM_OFF;
         r_dp_n       <= 1'b1;
         r_frame_tick <= 1'b0;
      end else begin
         r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
         if (w_slot_end) begin
            r_idx <= (r_idx == C_IDX_LAST) ? '0 : r_idx + 1'b1;
         end

         // A load landing on the wrap cycle bypasses the pending stage so it
         // is shown in the frame that starts next, and any older pending data
         // is dropped with it.
         if (load && w_frame_end) begin
            r_act    <= value;
            r_act_dp <= dp_in;
            r_pend_v <= 1'b0;
         end else begin
            if (w_frame_end && r_pend_v) begin
               r_act    <= r_pend;
               r_act_dp <= r_pend_dp;
               r_pend_v <= 1'b0;
            end
            if (load) begin
               r_pend    <= value;
               r_pend_dp <= dp_in;
               r_pend_v  <= 1'b1;
            end
         end

         r_number     <= r_act[r_idx];
         r_com_n      <= w_lit ? ~(C_ONE << r_idx) : C_COM_OFF;
         r_dp_n       <= w_lit ? ~r_act_dp[r_idx] : 1'b1;
         r_frame_tick <= w_frame_end;
      end
   end

   assign number     = r_number;
   assign com_n      = r_com_n;
   assign dp_n       = r_dp_n;
   assign frame_tick = r_frame_tick;

endmodule : fnd_scan
`default_nettype wire

// File: tb/tb_fnd_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fnd_scan                                                   |
// | Purpose  : Self-checking bench for fnd_scan with DIGITS=4, DIV=8,        |
// |            GUARD=2 (one frame = 32 cycles).                              |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fnd_scan;

   typedef struct {
      logic [15:0] value;
      logic [3:0]  dp;
      logic        blz;
      logic [3:0]  lit;   // hand-computed: digits not blanked
   } rec_t;

   logic        clk;
   logic        rst;
   logic [15:0] value;
   logic        load;
   logic [3:0]  dp_in;
   logic        blank_lz;
   logic [3:0]  number;
   logic [3:0]  com_n;
   logic        dp_n;
   logic        frame_tick;

   int n_checks;
   int n_fail;

   rec_t tab [7];
   rec_t r_zero, r_55, r_98;

   fnd_scan #(
      .DIGITS  (4),
      .CLK_HZ  (80),
      .SCAN_HZ (10),
      .GUARD   (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .value      (value),
      .load       (load),
      .dp_in      (dp_in),
      .blank_lz   (blank_lz),
      .number     (number),
      .com_n      (com_n),
      .dp_n       (dp_n),
      .frame_tick (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock edge, then compare the outputs against frame position j
   // (1..32) of a frame displaying e, or against reset values.
   task automatic check_edge(input rec_t e, input int j, input bit in_reset, input string tag);
      logic [9:0] exp_v;
      logic [9:0] act_v;
      int         c;
      int         d;
      logic       lit;
      logic [3:0] nib;
      logic [3:0] com;
      logic       dpn;
      @(posedge clk);
      #1;
      if (in_reset) begin
         exp_v = {4'h0, 4'hF, 1'b1, 1'b0};
      end else begin
         c   = (j - 1) % 8;
         d   = (j - 1) / 8;
         lit = (c >= 2) && e.lit[d];
         nib = e.value[d*4 +: 4];
         com = lit ? ~(4'b0001 << d) : 4'hF;
         dpn = lit ? ~e.dp[d] : 1'b1;
         exp_v = {nib, com, dpn, (j == 32)};
      end
      act_v = {number, com_n, dp_n, frame_tick};
      n_checks++;
      if (act_v !== exp_v) begin
         n_fail++;
         $display("FAIL %s j=%0d: got number=%h com_n=%b dp_n=%b tick=%b, want number=%h com_n=%b dp_n=%b tick=%b",
                  tag, j, act_v[9:6], act_v[5:2], act_v[1], act_v[0],
                  exp_v[9:6], exp_v[5:2], exp_v[1], exp_v[0]);
      end
   endtask

   // Check one whole frame showing e. Optional loads at edges la/lb and a
   // reset at edge rj (0 = unused); a reset aborts the frame.
   task automatic run_frame(input rec_t e, input string tag,
                            input int la, input logic [15:0] va, input logic [3:0] da,
                            input int lb, input logic [15:0] vb, input logic [3:0] db,
                            input int rj);
      for (int j = 1; j <= 32; j++) begin
         load = 1'b0;
         rst  = (j == rj);
         if (j == lb) begin
            load = 1'b1; value = vb; dp_in = db;
         end else if (j == la) begin
            load = 1'b1; value = va; dp_in = da;
         end
         if (j == rj) begin
            check_edge(e, j, 1'b1, {tag, "_rst"});
            rst  = 1'b0;
            load = 1'b0;
            return;
         end
         check_edge(e, j, 1'b0, tag);
      end
      load = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      load     = 1'b0;
      value    = '0;
      dp_in    = '0;
      blank_lz = 1'b0;

      r_zero = '{16'h0000, 4'b0000, 1'b0, 4'b1111};
      r_55   = '{16'h5555, 4'b0000, 1'b0, 4'b1111};
      r_98   = '{16'h9876, 4'b0100, 1'b0, 4'b1111};

      tab[0] = '{16'h1234, 4'b0000, 1'b0, 4'b1111};
      tab[1] = '{16'h0050, 4'b0000, 1'b1, 4'b0011};
      tab[2] = '{16'h0000, 4'b0000, 1'b1, 4'b0001};
      tab[3] = '{16'h9876, 4'b0100, 1'b0, 4'b1111};
      tab[4] = '{16'h0A00, 4'b1111, 1'b1, 4'b0111};
      tab[5] = '{16'h1000, 4'b0000, 1'b1, 4'b1111};
      tab[6] = '{16'h0000, 4'b0000, 1'b0, 4'b1111};

      // Reset state
      check_edge(r_zero, 0, 1'b1, "reset");
      check_edge(r_zero, 0, 1'b1, "reset_hold");
      rst = 1'b0;

      // Frame 0 shows the cleared act; each frame loads the next vector,
      // which must appear in the frame after the wrap.
      begin
         rec_t prev;
         prev = r_zero;
         for (int k = 0; k < 7; k++) begin
            run_frame(prev, $sformatf("vec%0d_prev", k), 5, tab[k].value, tab[k].dp,
                      0, 16'h0, 4'h0, 0);
            blank_lz = tab[k].blz;
            prev     = tab[k];
         end
      end

      // Two loads in one frame: current frame untouched, last one wins.
      run_frame(tab[6], "lastwins_cur", 3, 16'hAAAA, 4'h0, 20, 16'h5555, 4'h0, 0);
      // Pending load, then a load on the wrap cycle goes straight to act.
      run_frame(r_55, "lastwins_next", 10, 16'h1111, 4'h0, 32, 16'h9876, 4'b0100, 0);
      run_frame(r_98, "wrapload", 0, 16'h0, 4'h0, 0, 16'h0, 4'h0, 0);
      // Reset in digit 2's slot with a pending load and a load in the reset cycle.
      run_frame(r_98, "wrapload_hold", 5, 16'h4321, 4'h0, 20, 16'hFFFF, 4'hF, 20);
      run_frame(r_zero, "after_rst", 0, 16'h0, 4'h0, 0, 16'h0, 4'h0, 0);
      run_frame(r_zero, "after_rst2", 0, 16'h0, 4'h0, 0, 16'h0, 4'h0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_fnd_scan
`default_nettype wire
